// File: rtl/reconstructor_deimpartit.sv
// reconstructor_deimpartit: sequential shift-and-add rebuilding D = q*b + r over N iterations
module reconstructor_deimpartit #(
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [N-1:0]   q,
  input  logic [N-1:0]   b,
  input  logic [N-1:0]   r,
  output logic [2*N-1:0] D,
  output logic           busy,
  output logic           ready
);
  localparam int CW = $clog2(N + 1);
  typedef enum logic [2:0] {INIT, LOAD, ADD, SHIFT, CORRECT, READY} state_t;
  state_t state_q, state_d;
  logic [N:0] p_q, p_d;
  logic [N-1:0] qr_q, qr_d, br_q, br_d, rr_q, rr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2*N-1:0] d_q, d_d;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= INIT;
      p_q <= '0;
      qr_q <= '0;
      br_q <= '0;
      rr_q <= '0;
      cnt_q <= '0;
      d_q <= '0;
    end else begin
      state_q <= state_d;
      p_q <= p_d;
      qr_q <= qr_d;
      br_q <= br_d;
      rr_q <= rr_d;
      cnt_q <= cnt_d;
      d_q <= d_d;
    end
  end
  always_comb begin
    state_d = INIT;
    case (state_q)
      INIT:    state_d = start ? LOAD : INIT;
      LOAD:    state_d = ADD;
      ADD:     state_d = SHIFT;
      SHIFT:   state_d = cnt_q > CW'(1) ? ADD : CORRECT;
      CORRECT: state_d = READY;
      default: state_d = INIT;
    endcase
  end
  always_comb begin
    busy = state_q == LOAD || state_q == ADD || state_q == SHIFT || state_q == CORRECT;
    ready = state_q == READY;
  end
  always_comb begin
    p_d = p_q;
    qr_d = qr_q;
    br_d = br_q;
    rr_d = rr_q;
    cnt_d = cnt_q;
    d_d = d_q;
    case (state_q)
      LOAD: begin
        p_d = '0;
        qr_d = q;
        br_d = b;
        rr_d = r;
        cnt_d = CW'(N);
      end
      ADD: p_d = qr_q[0] ? p_q + {1'b0, br_q} : p_q;
      SHIFT: begin
        {p_d, qr_d} = {p_q, qr_q} >> 1;
        cnt_d = cnt_q - 1'b1;
      end
      CORRECT: d_d = {p_q[N-1:0], qr_q} + {{N{1'b0}}, rr_q};
      default: ;
    endcase
  end
  assign D = d_q;
endmodule

// File: tb/tb_reconstructor_deimpartit.sv
// tb_reconstructor_deimpartit: randomized scoreboard bench for the shift-and-add reconstructor
module tb_reconstructor_deimpartit;
  localparam int N = 4;
  localparam int LAT = 2 * N + 2;
  logic clk = 0, reset = 1, start = 0;
  logic [N-1:0] q = 0, b = 0, r = 0;
  logic [2*N-1:0] D;
  logic busy, ready;
  int cyc = 0, tests = 0, fails = 0, exp_d = 0;
  typedef struct {int d; int e0;} exp_t;
  exp_t sb[$];
  reconstructor_deimpartit #(.N(N)) dut (
    .clk(clk), .reset(reset), .start(start), .q(q), .b(b), .r(r),
    .D(D), .busy(busy), .ready(ready)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, req, cyc);
    end
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      if (ready) begin
        chk("busy_in_ready", int'(busy), 0);
        if (sb.size() == 0) chk("unexpected_ready", 1, 0);
        else begin
          e = sb.pop_front();
          exp_d = e.d;
          chk("result_D", int'(D), e.d);
          chk("latency", cyc - e.e0, LAT);
        end
      end else chk("D_hold", int'(D), exp_d);
    end
  end
  task automatic issue(input int qq, input int bb, input int rr);
    @(negedge clk);
    q = N'(qq);
    b = N'(bb);
    r = N'(rr);
    start = 1;
    sb.push_back('{qq * bb + rr, cyc + 1});
    @(negedge clk);
    start = 0;
  endtask
  task automatic wait_ready();
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!ready && k < 40);
    if (!ready) chk("ready_timeout", 0, 1);
  endtask
  initial begin
    repeat (3) @(negedge clk);
    chk("reset_D", int'(D), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_ready", int'(ready), 0);
    reset = 0;
    issue(13, 5, 2);
    wait_ready();
    issue(15, 15, 15);
    wait_ready();
    issue(0, 9, 7);
    wait_ready();
    issue(11, 0, 3);
    wait_ready();
    @(negedge clk);
    q = 3; b = 4; r = 1; start = 1;
    sb.push_back('{13, cyc + 1});
    wait_ready();
    q = 7; b = 2; r = 0;
    sb.push_back('{14, cyc + 2});
    wait_ready();
    q = 1; b = 1; r = 1;
    sb.push_back('{2, cyc + 2});
    wait_ready();
    start = 0;
    issue(9, 7, 4);
    repeat (3) @(negedge clk);
    start = 1;
    q = N'($urandom); b = N'($urandom); r = N'($urandom);
    @(negedge clk);
    start = 0;
    wait_ready();
    issue(5, 5, 5);
    repeat (6) @(negedge clk);
    reset = 1;
    sb.delete();
    exp_d = 0;
    @(negedge clk);
    chk("midreset_busy", int'(busy), 0);
    chk("midreset_ready", int'(ready), 0);
    chk("midreset_D", int'(D), 0);
    reset = 0;
    repeat (15) @(negedge clk);
    issue(6, 6, 5);
    wait_ready();
    for (int i = 0; i < 20; i++) begin
      issue($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15));
      wait_ready();
    end
    repeat (3) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
